// File: rtl/pim_buf_loader.sv
// pim_buf_loader
// ---------------------------------------------------------------------------
// DMA-style fill engine that copies a block of 32-bit words from a source
// memory port into the PIM buffer SRAM (7168 x 32b) using full-word writes.
// Up to MAX_OUTSTANDING source reads are kept in flight. Their in-order
// responses land in a small registered FIFO. The FIFO drains into the buffer
// at one word per cycle.
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_start            start pulse, only looked at in IDLE
//   i_src_addr         source byte address (word aligned)
//   i_dst_addr         buffer byte address (word aligned)
//   i_len_words        number of words to copy
//   o_busy/o_done      transfer in progress / one-cycle completion pulse
//   o_err              sticky config error, cleared by the next accepted start
//   o_src_req/o_src_addr, i_src_gnt, i_src_rvalid/i_src_rdata
//                      source read request / response channel
//   o_buf_addr/o_buf_wr_data/o_buf_size/o_buf_write
//                      buffer write port (full-word writes only)
//   o_buf_read         SRAM GWEN, active-low write enable; low only on writes
//
// Build option
//   PIM_LOADER_CHECKSUM_EN  adds o_checksum. On each write it becomes
//                           rotl(o_checksum, 1) ^ wr_data. It is final in
//                           the o_done cycle.
// ---------------------------------------------------------------------------
module pim_buf_loader #(
    parameter int MEM_DEPTH       = 28672,
    parameter int MEM_ADDR_WIDTH  = 15,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_src_addr,
    input  logic [31:0] i_dst_addr,
    input  logic [15:0] i_len_words,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_src_req,
    output logic [31:0] o_src_addr,
    input  logic        i_src_gnt,
    input  logic        i_src_rvalid,
    input  logic [31:0] i_src_rdata,
    output logic [31:0] o_buf_addr,
    output logic [31:0] o_buf_wr_data,
    output logic [3:0]  o_buf_size,
    output logic        o_buf_write,
    output logic        o_buf_read
`ifdef PIM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0] o_checksum
`endif
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] MAX_OUT = (CNT_W + 1)'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t                    state_q;
    logic [31:0]               src_addr_q;
    logic [MEM_ADDR_WIDTH-1:0] dst_ptr_q;
    logic [15:0]               len_q;
    logic [15:0]               req_left_q;
    logic [15:0]               wr_cnt_q;
    logic [CNT_W-1:0]          outstanding_q;
    logic [CNT_W-1:0]          fifo_count_q;
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [31:0]               fifo_q [MAX_OUTSTANDING];
    logic                      err_q;
`ifdef PIM_LOADER_CHECKSUM_EN
    logic [31:0]               checksum_q;
`endif

    logic [CNT_W:0]   inflight;
    logic             src_req;
    logic             grant;
    logic             push;
    logic             pop;
    logic [31:0]      fifo_head;
    logic [CNT_W-1:0] outstanding_d;
    logic [CNT_W-1:0] fifo_count_d;
    logic [15:0]      wr_cnt_d;
    logic [33:0]      cfg_end;
    logic             cfg_bad;

    // Reads in flight plus words already buffered are both counted. The FIFO
    // then always has a free slot for every response that can still arrive.
    assign inflight      = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
    assign src_req       = (state_q == RUN) && (req_left_q != 16'd0) && (inflight < MAX_OUT);
    assign grant         = src_req && i_src_gnt;
    assign push          = i_src_rvalid;
    assign pop           = ((state_q == RUN) || (state_q == DRAIN)) && (fifo_count_q != '0);
    assign fifo_head     = fifo_q[rd_ptr_q];
    assign outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(push);
    assign fifo_count_d  = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
    assign wr_cnt_d      = wr_cnt_q + 16'(pop);

    // The end address is computed 34 bits wide, so a huge length cannot wrap
    // back into range.
    assign cfg_end = {2'b00, i_dst_addr} + {16'd0, i_len_words, 2'b00};
    assign cfg_bad = (i_src_addr[1:0] != 2'b00) || (i_dst_addr[1:0] != 2'b00) ||
                     (cfg_end > 34'(MEM_DEPTH));

    // Status and request outputs come straight from registered state.
    // The buffer port shows the FIFO head during a pop cycle and is zero
    // otherwise.
    assign o_busy        = (state_q == RUN) || (state_q == DRAIN);
    assign o_done        = (state_q == FIN);
    assign o_err         = err_q;
    assign o_src_req     = src_req;
    assign o_src_addr    = src_addr_q;
    assign o_buf_write   = pop;
    assign o_buf_read    = !pop;
    assign o_buf_size    = pop ? 4'hF : 4'h0;
    assign o_buf_addr    = pop ? 32'(dst_ptr_q) : 32'd0;
    assign o_buf_wr_data = pop ? fifo_head : 32'd0;
`ifdef PIM_LOADER_CHECKSUM_EN
    assign o_checksum    = checksum_q;
`endif

    // The response FIFO storage has no reset. Its contents are only
    // observable through a pop, and a pop needs a non-zero count.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= i_src_rdata;
        end
    end

    // Control FSM with its counters and pointers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            src_addr_q    <= '0;
            dst_ptr_q     <= '0;
            len_q         <= '0;
            req_left_q    <= '0;
            wr_cnt_q      <= '0;
            outstanding_q <= '0;
            fifo_count_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            err_q         <= 1'b0;
`ifdef PIM_LOADER_CHECKSUM_EN
            checksum_q    <= '0;
`endif
        end else begin
            outstanding_q <= outstanding_d;
            fifo_count_q  <= fifo_count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
                dst_ptr_q <= dst_ptr_q + MEM_ADDR_WIDTH'(4);
                wr_cnt_q  <= wr_cnt_d;
`ifdef PIM_LOADER_CHECKSUM_EN
                checksum_q <= {checksum_q[30:0], checksum_q[31]} ^ fifo_head;
`endif
            end

            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        src_addr_q <= i_src_addr;
                        dst_ptr_q  <= i_dst_addr[MEM_ADDR_WIDTH-1:0];
                        len_q      <= i_len_words;
                        req_left_q <= i_len_words;
                        wr_cnt_q   <= '0;
                        err_q      <= 1'b0;
`ifdef PIM_LOADER_CHECKSUM_EN
                        checksum_q <= '0;
`endif
                        if (cfg_bad) begin
                            err_q   <= 1'b1;
                            state_q <= FIN;
                        end else if (i_len_words == 16'd0) begin
                            state_q <= FIN;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (grant) begin
                        src_addr_q <= src_addr_q + 32'd4;
                        req_left_q <= req_left_q - 16'd1;
                        if (req_left_q == 16'd1) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Next-cycle values are tested so that done follows the
                    // final write by exactly one cycle.
                    if ((outstanding_d == '0) && (fifo_count_d == '0) && (wr_cnt_d == len_q)) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pim_buf_loader.sv
// Directed testbench for pim_buf_loader.
// A source-memory responder grants requests and returns in-order data after a
// configurable delay. A monitor in the same negedge process logs every buffer
// write, done pulse and request cycle. The main sequence checks those logs
// against hand-computed expectations.
module tb_pim_buf_loader;

    logic        clk = 1'b0;
    logic        iRst;
    logic        iStart;
    logic [31:0] iSrcAddr;
    logic [31:0] iDstAddr;
    logic [15:0] iLenWords;
    logic        oBusy;
    logic        oDone;
    logic        oErr;
    logic        oSrcReq;
    logic [31:0] oSrcAddr;
    logic        iSrcGnt;
    logic        iSrcRvalid;
    logic [31:0] iSrcRdata;
    logic [31:0] oBufAddr;
    logic [31:0] oBufWrData;
    logic [3:0]  oBufSize;
    logic        oBufWrite;
    logic        oBufRead;
`ifdef PIM_LOADER_CHECKSUM_EN
    logic [31:0] oChecksum;
    logic [31:0] doneChecksum;
`endif

    pim_buf_loader dut (
        .i_clk        (clk),
        .i_rst        (iRst),
        .i_start      (iStart),
        .i_src_addr   (iSrcAddr),
        .i_dst_addr   (iDstAddr),
        .i_len_words  (iLenWords),
        .o_busy       (oBusy),
        .o_done       (oDone),
        .o_err        (oErr),
        .o_src_req    (oSrcReq),
        .o_src_addr   (oSrcAddr),
        .i_src_gnt    (iSrcGnt),
        .i_src_rvalid (iSrcRvalid),
        .i_src_rdata  (iSrcRdata),
        .o_buf_addr   (oBufAddr),
        .o_buf_wr_data(oBufWrData),
        .o_buf_size   (oBufSize),
        .o_buf_write  (oBufWrite),
        .o_buf_read   (oBufRead)
`ifdef PIM_LOADER_CHECKSUM_EN
        ,
        .o_checksum   (oChecksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int doneCnt = 0;
    int doneCycle = 0;
    int startCycle = 0;
    int reqCycles = 0;
    int readBad = 0;
    int maxOut = 0;
    int gntMode = 0;
    int delayMin = 1;
    int delayMax = 1;
    int lastDue = 0;
    logic [31:0] salt = 32'hC0DE0000;

    logic [31:0] wrAddr[$];
    logic [31:0] wrData[$];
    logic [31:0] wrSize[$];
    int          wrCycle[$];
    int          dueQ[$];
    logic [31:0] addrQ[$];

    // Source memory content: word index XOR a salt.
    function automatic logic [31:0] srcData(input logic [31:0] a);
        return (a >> 2) ^ salt;
    endfunction

    // Mid-cycle monitor and source responder.
    initial begin
        iSrcGnt = 1'b0;
        iSrcRvalid = 1'b0;
        iSrcRdata = 32'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (oBufWrite === 1'b1) begin
                wrAddr.push_back(oBufAddr);
                wrData.push_back(oBufWrData);
                wrSize.push_back(32'(oBufSize));
                wrCycle.push_back(cyc);
            end
            if (oBufRead !== !oBufWrite) readBad++;
            if (oDone === 1'b1) begin
                doneCnt++;
                doneCycle = cyc;
`ifdef PIM_LOADER_CHECKSUM_EN
                doneChecksum = oChecksum;
`endif
            end
            if (oSrcReq === 1'b1) reqCycles++;
            if (iStart === 1'b1) startCycle = cyc;
            if (iRst === 1'b1) begin
                dueQ = {};
                addrQ = {};
                lastDue = cyc;
                iSrcRvalid = 1'b0;
                iSrcRdata = 32'd0;
                iSrcGnt = 1'b0;
            end else begin
                if (dueQ.size() > 0 && dueQ[0] <= cyc) begin
                    iSrcRvalid = 1'b1;
                    iSrcRdata = srcData(addrQ[0]);
                    void'(dueQ.pop_front());
                    void'(addrQ.pop_front());
                end else begin
                    iSrcRvalid = 1'b0;
                    iSrcRdata = 32'd0;
                end
                iSrcGnt = (gntMode == 0) ? 1'b1 : ((cyc % 4) == 0);
                if (oSrcReq === 1'b1 && iSrcGnt) begin
                    int due;
                    due = cyc + int'($urandom_range(delayMax, delayMin));
                    if (due <= lastDue) due = lastDue + 1;
                    lastDue = due;
                    dueQ.push_back(due);
                    addrQ.push_back(oSrcAddr);
                end
                if (dueQ.size() > maxOut) maxOut = dueQ.size();
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Clears the logs and pulses start for one cycle with the given config.
    task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
        wrAddr = {};
        wrData = {};
        wrSize = {};
        wrCycle = {};
        doneCnt = 0;
        reqCycles = 0;
        readBad = 0;
        maxOut = 0;
        iSrcAddr = src;
        iDstAddr = dst;
        iLenWords = len;
        iStart = 1'b1;
        tick(1);
        iStart = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while (doneCnt == 0 && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput({tag, "_done_seen"}, 32'(doneCnt != 0), 32'd1);
    endtask

    task automatic checkWrites(input string tag, input logic [31:0] src, input logic [31:0] dst, input int n);
        checkOutput({tag, "_write_count"}, 32'(wrAddr.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] s;
            a = (i < wrAddr.size()) ? wrAddr[i] : 32'hxxxxxxxx;
            d = (i < wrData.size()) ? wrData[i] : 32'hxxxxxxxx;
            s = (i < wrSize.size()) ? wrSize[i] : 32'hxxxxxxxx;
            checkOutput($sformatf("%s_addr%0d", tag, i), a, dst + 32'(4 * i));
            checkOutput($sformatf("%s_data%0d", tag, i), d, srcData(src + 32'(4 * i)));
            checkOutput($sformatf("%s_size%0d", tag, i), s, 32'hF);
        end
        checkOutput({tag, "_gwen"}, 32'(readBad), 32'd0);
    endtask

    initial begin
        iRst = 1'b1;
        iStart = 1'b0;
        iSrcAddr = 32'd0;
        iDstAddr = 32'd0;
        iLenWords = 16'd0;
        tick(3);

        // Reset state
        checkOutput("rst_busy", 32'(oBusy), 32'd0);
        checkOutput("rst_done", 32'(oDone), 32'd0);
        checkOutput("rst_err", 32'(oErr), 32'd0);
        checkOutput("rst_src_req", 32'(oSrcReq), 32'd0);
        checkOutput("rst_src_addr", oSrcAddr, 32'd0);
        checkOutput("rst_buf_write", 32'(oBufWrite), 32'd0);
        checkOutput("rst_buf_read", 32'(oBufRead), 32'd1);
        checkOutput("rst_buf_size", 32'(oBufSize), 32'd0);
        checkOutput("rst_buf_addr", oBufAddr, 32'd0);
        checkOutput("rst_buf_data", oBufWrData, 32'd0);
`ifdef PIM_LOADER_CHECKSUM_EN
        checkOutput("rst_checksum", oChecksum, 32'd0);
`endif
        iRst = 1'b0;
        tick(2);

        // Basic copy, continuous grant, one-cycle response
        gntMode = 0; delayMin = 1; delayMax = 1;
        applyStimulus(32'h1000, 32'h0, 16'd4);
        checkOutput("basic_busy", 32'(oBusy), 32'd1);
        waitDone("basic", 100);
        tick(3);
        checkWrites("basic", 32'h1000, 32'h0, 4);
        checkOutput("basic_done_gap", 32'(doneCycle - ((wrCycle.size() > 0) ? wrCycle[wrCycle.size()-1] : 0)), 32'd1);
        checkOutput("basic_back_to_back", 32'((wrCycle.size() == 4) ? (wrCycle[3] - wrCycle[0]) : -1), 32'd3);
        checkOutput("basic_done_count", 32'(doneCnt), 32'd1);
        checkOutput("basic_err", 32'(oErr), 32'd0);

        // Backpressure: grant one cycle in four, response delay 1..5
        gntMode = 1; delayMin = 1; delayMax = 5;
        applyStimulus(32'h2000, 32'h100, 16'd8);
        waitDone("bp", 400);
        tick(3);
        checkWrites("bp", 32'h2000, 32'h100, 8);
        checkOutput("bp_max_outstanding_ok", 32'(maxOut <= 4), 32'd1);
        checkOutput("bp_done_count", 32'(doneCnt), 32'd1);

        // Destination range error
        gntMode = 0; delayMin = 1; delayMax = 1;
        applyStimulus(32'h1000, 32'h6FFC, 16'd2);
        waitDone("err_dst", 20);
        tick(3);
        checkOutput("err_dst_err", 32'(oErr), 32'd1);
        checkOutput("err_dst_req", 32'(reqCycles), 32'd0);
        checkOutput("err_dst_writes", 32'(wrAddr.size()), 32'd0);
        checkOutput("err_dst_done_count", 32'(doneCnt), 32'd1);

        // Misaligned source error
        applyStimulus(32'h1002, 32'h0, 16'd1);
        waitDone("err_src", 20);
        tick(3);
        checkOutput("err_src_err", 32'(oErr), 32'd1);
        checkOutput("err_src_req", 32'(reqCycles), 32'd0);
        checkOutput("err_src_writes", 32'(wrAddr.size()), 32'd0);

        // Zero length also clears the sticky error
        applyStimulus(32'h1000, 32'h0, 16'd0);
        waitDone("zero", 20);
        tick(3);
        checkOutput("zero_latency_ok", 32'((doneCycle - startCycle) <= 2), 32'd1);
        checkOutput("zero_err", 32'(oErr), 32'd0);
        checkOutput("zero_req", 32'(reqCycles), 32'd0);
        checkOutput("zero_writes", 32'(wrAddr.size()), 32'd0);

        // Start while busy is ignored
        gntMode = 0; delayMin = 2; delayMax = 2;
        applyStimulus(32'h3000, 32'h200, 16'd6);
        tick(2);
        checkOutput("busy_in_run", 32'(oBusy), 32'd1);
        iSrcAddr = 32'h0;
        iDstAddr = 32'h0;
        iLenWords = 16'd1;
        iStart = 1'b1;
        tick(1);
        iStart = 1'b0;
        waitDone("busy", 100);
        tick(3);
        checkWrites("busy", 32'h3000, 32'h200, 6);
        checkOutput("busy_done_count", 32'(doneCnt), 32'd1);

        // Reset after two writes aborts without a done pulse
        delayMin = 1; delayMax = 1;
        applyStimulus(32'h4000, 32'h400, 16'd8);
        begin
            int n = 0;
            while (wrAddr.size() < 2 && n < 50) begin
                tick(1);
                n++;
            end
        end
        checkOutput("rstmid_two_writes", 32'(wrAddr.size() >= 2), 32'd1);
        iRst = 1'b1;
        tick(1);
        checkOutput("rstmid_busy", 32'(oBusy), 32'd0);
        checkOutput("rstmid_buf_read", 32'(oBufRead), 32'd1);
        checkOutput("rstmid_buf_write", 32'(oBufWrite), 32'd0);
        iRst = 1'b0;
        tick(6);
        checkOutput("rstmid_no_done", 32'(doneCnt), 32'd0);
        applyStimulus(32'h5000, 32'h800, 16'd3);
        waitDone("fresh", 100);
        tick(3);
        checkWrites("fresh", 32'h5000, 32'h800, 3);
        checkOutput("fresh_done_count", 32'(doneCnt), 32'd1);

`ifdef PIM_LOADER_CHECKSUM_EN
        // Data 0x1, 0x2 gives rotl(0x1) ^ 0x2 = 0
        salt = 32'd0;
        applyStimulus(32'h4, 32'h0, 16'd2);
        waitDone("csum", 100);
        tick(3);
        checkWrites("csum", 32'h4, 32'h0, 2);
        checkOutput("csum_value", doneChecksum, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pim_buf_loader.md
Name: pim_buf_loader

Overview:
- DMA-style fill engine directly upstream of the PIM buffer SRAM (7168 x 32b).
- Copies a block of 32-bit words from a source memory port into the buffer using full-word writes.
- Keeps up to MAX_OUTSTANDING source reads in flight and buffers their responses in a small FIFO.
- Driven by the core through start, address and length inputs; reports busy, done and error status.

Parameters:
- MEM_DEPTH, 28672, buffer size in bytes
- MEM_ADDR_WIDTH, 15, buffer byte-address width
- MAX_OUTSTANDING, 4, maximum source reads in flight; also the response FIFO depth (power of 2, 2..16)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  start pulse; sampled only in IDLE
- i_src_addr  in  32  source byte address, word aligned
- i_dst_addr  in  32  buffer byte address, word aligned
- i_len_words  in  16  number of words to copy
- o_busy  out  1  transfer in progress
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  sticky error flag; cleared by the next accepted start
- o_src_req  out  1  source read request
- o_src_addr  out  32  source read address
- i_src_gnt  in  1  request accepted this cycle
- i_src_rvalid  in  1  read data valid; responses return in order
- i_src_rdata  in  32  read data
- o_buf_addr  out  32  buffer byte address
- o_buf_wr_data  out  32  buffer write data
- o_buf_size  out  4  byte enables; 4'hF on every write
- o_buf_write  out  1  buffer write strobe
- o_buf_read  out  1  drives the SRAM GWEN (active-low global write enable); 1 in every cycle except a write cycle

Behaviour:
- Reset values:
  - o_busy, o_done, o_err, o_src_req, o_buf_write = 0
  - o_buf_read = 1, o_buf_size = 0
  - all addresses and data = 0
  - FIFO and counters cleared, state IDLE
- Reset mid-transfer aborts the transfer with no done pulse. The source fabric is reset in the same cycle.
- States: IDLE, RUN, DRAIN, FIN.
- IDLE, on i_start:
  - Latch the config and clear o_err.
  - Error check: addresses not word aligned, or i_dst_addr + 4*i_len_words > MEM_DEPTH. On error, set o_err and go to FIN with no accesses.
  - If i_len_words == 0, go to FIN with no accesses.
  - Otherwise go to RUN; o_busy = 1 from the next cycle.
- RUN:
  - o_src_req = 1 while requests remain and (outstanding + fifo_count) < MAX_OUTSTANDING.
  - Each cycle with req & gnt advances o_src_addr by 4 and increments outstanding.
  - When the last request is granted, go to DRAIN.
- i_src_rvalid, in any state: push i_src_rdata into the FIFO and decrement outstanding. Gating guarantees the FIFO never overflows.
- Buffer write, in RUN or DRAIN:
  - When the FIFO is non-empty, pop one word per cycle.
  - Drive o_buf_write = 1, o_buf_read = 0, o_buf_size = 4'hF, o_buf_addr = dst pointer, o_buf_wr_data = FIFO head.
  - The dst pointer advances by 4 per write.
  - Minimum latency from rvalid to buffer write is 1 cycle; the FIFO is registered with no bypass.
- Simultaneous push and pop in the same cycle: fifo_count is unchanged.
- DRAIN: when outstanding == 0, the FIFO is empty and the words written == len, go to FIN.
- FIN: o_done = 1 for one cycle, o_busy = 0 in the same cycle, then return to IDLE.
- i_start while busy or in FIN is ignored.
- The dst pointer is MEM_ADDR_WIDTH bits wide. The range check makes wrap-around unreachable.
- Back-to-back steady-state throughput is 1 word per cycle when gnt and rvalid are continuous.

Optional Feature:
- Macro: PIM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output port o_checksum (32 bits), reset to 0 and cleared on an accepted start.
  - On each buffer write, o_checksum becomes (o_checksum rotated left by 1) XOR wr_data.
  - The final value is valid in the o_done cycle.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic copy: src 0x1000, dst 0x0, len 4, gnt = 1, rvalid 1 cycle after grant.
  -> 4 writes to addrs 0x0, 0x4, 0x8, 0xC with matching data, size 4'hF, o_buf_read = 0 only on those cycles; o_done one cycle after the last write; o_err = 0.
- Backpressure: len 8, gnt low 3 of every 4 cycles, rvalid delays 1..5 cycles.
  -> outstanding never exceeds 4; all 8 words written in order; exactly one done pulse.
- Error cases:
  - dst 0x6FFC, len 2 -> o_err = 1, done pulse, zero o_src_req and zero o_buf_write.
  - src 0x1002 -> same response.
- Zero length and start while busy: len 0 -> done pulse within 2 cycles, no accesses; i_start asserted during RUN -> ignored, transfer unchanged.
- Reset mid-transfer: assert i_rst in RUN after 2 writes -> next cycle o_busy = 0, o_buf_read = 1, no done pulse; a fresh start then copies correctly.
- Checksum (with PIM_LOADER_CHECKSUM_EN): data 0x1, 0x2 -> o_checksum = 0x00000000 at the o_done cycle (rol(0x1) XOR 0x2 = 0x0).
